// File: rtl/fetch_align_buffer_pkg.sv
// Shared constants, bus payload structs and helpers for the fetch align buffer.
package fetch_align_buffer_pkg;

  // Canonical nop (addi x0, x0, 0) presented to decode when no instruction is ready
  localparam logic [31:0] nop_instr = 32'h0000_0013;

  // Width-independent request/control signals entering the buffer
  typedef struct packed {
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        flush;
    logic [31:0] flush_pc;
    logic        instr_ready;
  } fetch_buffer_in_type;

  // Signals presented to the fetch unit and the decode stage
  typedef struct packed {
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_npc;
    logic        instr_compressed;
    logic [31:0] exp_addr;
  } fetch_buffer_out_type;

  // A halfword starts a 16-bit instruction unless its two low bits are 2'b11
  function automatic logic is_compressed(input logic [1:0] lsb);
    return lsb != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_buffer_ram.sv
// Halfword storage ring for the fetch align buffer.
// Ports:
//   clock             - clock
//   wr_en             - write one fetch word this cycle
//   wr_ptr            - ring slot receiving the first kept halfword
//   wr_skip           - number of leading halfwords of wr_data to drop
//   wr_data           - fetch word, little-endian halfwords
//   rd_ptr            - head slot
//   rd_data0/rd_data1 - halfwords at rd_ptr and rd_ptr+1 (wrapping)
module fetch_buffer_ram #(
  parameter  int unsigned DEPTH  = 8,
  parameter  int unsigned WR_HW  = 2,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned SKIP_W = (WR_HW > 1) ? $clog2(WR_HW) : 1
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_ptr,
  input  logic [SKIP_W-1:0]     wr_skip,
  input  logic [16*WR_HW-1:0]   wr_data,
  input  logic [PTR_W-1:0]      rd_ptr,
  output logic [15:0]           rd_data0,
  output logic [15:0]           rd_data1
);

  logic [15:0] mem [DEPTH];

  // Halfword i of the word lands at wr_ptr + (i - skip); pointer width wraps the ring
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < int'(WR_HW); i++) begin
        if (i >= int'(wr_skip)) begin
          mem[wr_ptr + PTR_W'(i) - PTR_W'(wr_skip)] <= wr_data[16*i +: 16];
        end
      end
    end
  end

  assign rd_data0 = mem[rd_ptr];
  assign rd_data1 = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/fetch_align_buffer.sv
// Halfword instruction queue between imem responses and decode. Re-aligns
// aligned fetch words into 16/32-bit instructions, absorbs decode stalls,
// handles instructions straddling fetch words and drops stale responses.
// Ports:
//   clock, reset          - clock, asynchronous active-high reset
//   fetch_valid/addr/rdata- imem response word
//   fetch_ready           - room for one full fetch word
//   flush, flush_pc       - redirect and its 2-byte aligned target
//   instr_ready           - decode consumes the head instruction
//   instr_valid, instr    - head instruction (nop_instr when not valid)
//   instr_pc, instr_npc   - pc of head and pc of the following instruction
//   instr_compressed      - head instruction is 16-bit
//   exp_addr              - next fetch address the buffer will accept
//   count                 - occupied halfwords
module fetch_align_buffer
  import fetch_align_buffer_pkg::*;
#(
  parameter int unsigned FETCH_BYTES = 4,
  parameter int unsigned DEPTH       = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_addr,
  input  logic [8*FETCH_BYTES-1:0] fetch_rdata,
  output logic                     fetch_ready,
  input  logic                     flush,
  input  logic [31:0]              flush_pc,
  input  logic                     instr_ready,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic [31:0]              instr_npc,
  output logic                     instr_compressed,
  output logic [31:0]              exp_addr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned HW_PER_WORD = FETCH_BYTES / 2;
  localparam int unsigned PTR_W       = $clog2(DEPTH);
  localparam int unsigned CNT_W       = PTR_W + 1;
  localparam int unsigned OFF_W       = $clog2(FETCH_BYTES);
  localparam int unsigned SKIP_W      = OFF_W - 1;
  localparam logic [31:0] ALIGN_MASK  = ~(32'(FETCH_BYTES) - 32'd1);
  localparam logic [SKIP_W-1:0] RESET_SKIP = RESET_PC[OFF_W-1:1];

  fetch_buffer_in_type  fb_in;
  fetch_buffer_out_type fb_out;

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       head_pc_q, head_pc_d;
  logic [31:0]       exp_addr_q, exp_addr_d;
  logic [SKIP_W-1:0] skip_q, skip_d;

  logic [15:0]      rd_hw0, rd_hw1;
  logic             head_valid, head_is_c;
  logic             accept, pop;
  logic [CNT_W-1:0] pushed, popped;

  // Group the width-independent inputs
  always_comb begin : pack_inputs
    fb_in             = '0;
    fb_in.fetch_valid = fetch_valid;
    fb_in.fetch_addr  = fetch_addr;
    fb_in.flush       = flush;
    fb_in.flush_pc    = flush_pc;
    fb_in.instr_ready = instr_ready;
  end

  fetch_buffer_ram #(
    .DEPTH (DEPTH),
    .WR_HW (HW_PER_WORD)
  ) u_ram (
    .clock    (clock),
    .wr_en    (accept),
    .wr_ptr   (wr_ptr_q),
    .wr_skip  (skip_q),
    .wr_data  (fetch_rdata),
    .rd_ptr   (rd_ptr_q),
    .rd_data0 (rd_hw0),
    .rd_data1 (rd_hw1)
  );

  // Head decode from registered state only; a 32-bit head needs both halves present
  always_comb begin : head_decode
    head_is_c  = (count_q != '0) & is_compressed(rd_hw0[1:0]);
    head_valid = head_is_c | (count_q >= CNT_W'(2));

    fb_out                  = '0;
    fb_out.fetch_ready      = (CNT_W'(DEPTH) - count_q) >= CNT_W'(HW_PER_WORD);
    fb_out.instr_valid      = head_valid;
    fb_out.instr            = nop_instr;
    if (head_valid) begin
      fb_out.instr = head_is_c ? {16'h0000, rd_hw0} : {rd_hw1, rd_hw0};
    end
    fb_out.instr_pc         = head_pc_q;
    fb_out.instr_npc        = head_pc_q + (head_is_c ? 32'd2 : 32'd4);
    fb_out.instr_compressed = head_is_c;
    fb_out.exp_addr         = exp_addr_q;
  end

  // Next state: flush overrides push and pop; fetch_ready was computed before any pop
  always_comb begin : next_state
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    head_pc_d  = head_pc_q;
    exp_addr_d = exp_addr_q;
    skip_d     = skip_q;

    accept = fb_in.fetch_valid & fb_out.fetch_ready &
             (fb_in.fetch_addr == exp_addr_q) & ~fb_in.flush;
    pop    = fb_out.instr_valid & fb_in.instr_ready & ~fb_in.flush;
    pushed = accept ? (CNT_W'(HW_PER_WORD) - CNT_W'(skip_q)) : '0;
    popped = pop ? (head_is_c ? CNT_W'(1) : CNT_W'(2)) : '0;

    if (fb_in.flush) begin
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      head_pc_d  = fb_in.flush_pc;
      exp_addr_d = fb_in.flush_pc & ALIGN_MASK;
      skip_d     = fb_in.flush_pc[OFF_W-1:1];
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(pushed);
      rd_ptr_d = rd_ptr_q + PTR_W'(popped);
      count_d  = count_q + pushed - popped;
      if (pop) begin
        head_pc_d = fb_out.instr_npc;
      end
      if (accept) begin
        exp_addr_d = exp_addr_q + 32'(FETCH_BYTES);
        skip_d     = '0;
      end
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      head_pc_q  <= RESET_PC;
      exp_addr_q <= RESET_PC & ALIGN_MASK;
      skip_q     <= RESET_SKIP;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      head_pc_q  <= head_pc_d;
      exp_addr_q <= exp_addr_d;
      skip_q     <= skip_d;
    end
  end

  assign fetch_ready      = fb_out.fetch_ready;
  assign instr_valid      = fb_out.instr_valid;
  assign instr            = fb_out.instr;
  assign instr_pc         = fb_out.instr_pc;
  assign instr_npc        = fb_out.instr_npc;
  assign instr_compressed = fb_out.instr_compressed;
  assign exp_addr         = fb_out.exp_addr;
  assign count            = count_q;

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer (FETCH_BYTES=4, DEPTH=8, RESET_PC=0).
// Expected instructions are queued when their fetch word is driven and
// compared whenever decode takes the head instruction.
module tb_fetch_align_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        comp;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic [31:0] fetch_rdata = '0;
  logic        fetch_ready;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc, instr_npc;
  logic        instr_compressed;
  logic [31:0] exp_addr;
  logic [3:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;
  exp_t sb_q[$];

  fetch_align_buffer #(
    .FETCH_BYTES (4),
    .DEPTH       (8),
    .RESET_PC    (32'h0)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .fetch_valid      (fetch_valid),
    .fetch_addr       (fetch_addr),
    .fetch_rdata      (fetch_rdata),
    .fetch_ready      (fetch_ready),
    .flush            (flush),
    .flush_pc         (flush_pc),
    .instr_ready      (instr_ready),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_npc        (instr_npc),
    .instr_compressed (instr_compressed),
    .exp_addr         (exp_addr),
    .count            (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_instr(input logic [31:0] i, input logic [31:0] pc, input logic c);
    exp_t e;
    e.instr = i;
    e.pc    = pc;
    e.npc   = pc + (c ? 32'd2 : 32'd4);
    e.comp  = c;
    sb_q.push_back(e);
  endtask

  // Compare the head against the scoreboard when decode takes it at the coming edge
  task automatic sb_check();
    exp_t e;
    if (instr_valid && instr_ready && !flush) begin
      n_cmp++;
      assert (sb_q.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed instr 0x%08h pc 0x%08h expected no instruction", instr, instr_pc);
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_instr", instr, e.instr);
        chk("sb_pc", instr_pc, e.pc);
        chk("sb_npc", instr_npc, e.npc);
        chk("sb_comp", 32'(instr_compressed), 32'(e.comp));
      end
    end
  endtask

  // Sample mid-cycle, take the edge, then return 1 time unit after it
  task automatic tick();
    @(negedge clock);
    sb_check();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_word(input logic [31:0] a, input logic [31:0] d);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    fetch_rdata = d;
    tick();
    fetch_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_exp_addr", exp_addr, 32'h0);
    reset = 1'b0;
    instr_ready = 1'b1;

    // 32-bit instruction, visible the cycle after acceptance
    expect_instr(32'h00A00093, 32'h0, 1'b0);
    fetch_word(32'h0, 32'h00A00093);
    chk("lat_valid", 32'(instr_valid), 32'd1);

    // Two compressed instructions in one word
    expect_instr(32'h00004501, 32'h4, 1'b1);
    expect_instr(32'h00004505, 32'h6, 1'b1);
    fetch_word(32'h4, 32'h45054501);

    // Straddling 32-bit instruction: lower half at 0xA, upper half in next word
    expect_instr(32'h00004501, 32'h8, 1'b1);
    fetch_word(32'h8, 32'h00934501);
    tick();
    tick();
    chk("straddle_valid", 32'(instr_valid), 32'd0);
    chk("straddle_pc", instr_pc, 32'hA);
    chk("straddle_instr", instr, NOP);
    chk("straddle_count", 32'(count), 32'd1);
    expect_instr(32'h00A00093, 32'hA, 1'b0);
    expect_instr(32'h00000001, 32'hE, 1'b1);
    fetch_word(32'hC, 32'h000100A0);
    tick();
    tick();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_exp_addr", exp_addr, 32'h10);

    // Redirect to an odd-halfword target
    flush = 1'b1;
    flush_pc = 32'h102;
    tick();
    flush = 1'b0;
    chk("flush_exp_addr", exp_addr, 32'h100);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(instr_valid), 32'd0);
    chk("flush_pc", instr_pc, 32'h102);
    fetch_word(32'h10, 32'hDEADBEEF);
    chk("stale_count", 32'(count), 32'd0);
    chk("stale_exp_addr", exp_addr, 32'h100);
    expect_instr(32'h00004505, 32'h102, 1'b1);
    fetch_word(32'h100, 32'h45050000);
    chk("skip_count", 32'(count), 32'd1);
    tick();
    chk("skip_exp_addr", exp_addr, 32'h104);

    // Fill to full under a decode stall
    instr_ready = 1'b0;
    expect_instr(32'h00108093, 32'h104, 1'b0);
    fetch_word(32'h104, 32'h00108093);
    expect_instr(32'h00210113, 32'h108, 1'b0);
    fetch_word(32'h108, 32'h00210113);
    expect_instr(32'h00318193, 32'h10C, 1'b0);
    fetch_word(32'h10C, 32'h00318193);
    expect_instr(32'h00420213, 32'h110, 1'b0);
    fetch_word(32'h110, 32'h00420213);
    chk("full_count", 32'(count), 32'd8);
    chk("full_fetch_ready", 32'(fetch_ready), 32'd0);
    fetch_word(32'h114, 32'h00528293);
    chk("full_drop_count", 32'(count), 32'd8);
    chk("full_drop_exp_addr", exp_addr, 32'h114);
    instr_ready = 1'b1;
    tick();
    chk("pop1_count", 32'(count), 32'd6);
    chk("pop1_fetch_ready", 32'(fetch_ready), 32'd1);
    tick();
    chk("pop2_count", 32'(count), 32'd4);
    instr_ready = 1'b0;
    expect_instr(32'h00528293, 32'h114, 1'b0);
    fetch_word(32'h114, 32'h00528293);
    chk("refetch_count", 32'(count), 32'd6);
    chk("refetch_exp_addr", exp_addr, 32'h118);
    instr_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("final_drain_count", 32'(count), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    // Build count=3 with decode stalled, then reset asynchronously mid-cycle
    instr_ready = 1'b0;
    flush = 1'b1;
    flush_pc = 32'h11A;
    tick();
    flush = 1'b0;
    fetch_word(32'h118, 32'h45010000);
    fetch_word(32'h11C, 32'h00934505);
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    chk("pre_rst_pc", instr_pc, 32'h11A);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(instr_valid), 32'd0);
    chk("async_rst_pc", instr_pc, 32'h0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_exp_addr", exp_addr, 32'h0);
    chk("async_rst_instr", instr, NOP);
    @(posedge clock);
    #1 reset = 1'b0;

    // Operation resumes from RESET_PC
    instr_ready = 1'b1;
    expect_instr(32'h00A00093, 32'h0, 1'b0);
    fetch_word(32'h0, 32'h00A00093);
    tick();
    chk("post_rst_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("post_rst_pc", instr_pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
